// File: rtl/cpu_work_ram.sv
// CPU-side work RAM responder: 2 KiB mirrored RAM below MAP_LIMIT,
// open-bus data for unmapped reads, fixed-latency read responses.
module cpu_work_ram #(
    parameter int          RAM_ADDRESS_WIDTH = 11,
    parameter logic [15:0] MAP_LIMIT         = 16'h2000,
    parameter int          READ_LATENCY      = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [15:0] address_i,
    input  logic        address_valid_i,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic        overrun_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t state, state_next;

    logic [2:0] count, count_next;
    logic [7:0] ram [2**RAM_ADDRESS_WIDTH];
    logic [7:0] ram_q;
    logic [7:0] open_bus;
    logic [7:0] data_q;
    logic [7:0] read_value;
    logic       mapped;
    logic       mapped_q;
    logic       accept_write;
    logic       accept_read;
    logic [RAM_ADDRESS_WIDTH-1:0] ram_address;

    assign ram_address  = address_i[RAM_ADDRESS_WIDTH-1:0];
    assign mapped       = address_i < MAP_LIMIT;
    assign accept_write = (state == IDLE) && address_valid_i && data_valid_i;
    assign accept_read  = (state == IDLE) && address_valid_i && !data_valid_i;

    // Nothing can modify RAM or open_bus while a read is pending,
    // so the value captured at accept time is still current here.
    assign read_value   = mapped_q ? ram_q : open_bus;

    assign data_valid_o = (state == RESPOND);
    assign data_o       = data_valid_o ? read_value : data_q;

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (accept_read) begin
                    if (READ_LATENCY == 1) begin
                        state_next = RESPOND;
                    end else begin
                        state_next = WAIT;
                        count_next = 3'(READ_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (count == 3'd1) begin
                    state_next = RESPOND;
                end else begin
                    count_next = count - 3'd1;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            count     <= 3'd0;
            open_bus  <= 8'h00;
            data_q    <= 8'h00;
            mapped_q  <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept_write) begin
                open_bus <= data_i;
            end
            if (accept_read) begin
                mapped_q <= mapped;
            end
            if (state == RESPOND) begin
                open_bus <= read_value;
                data_q   <= read_value;
            end
            if (address_valid_i && (state != IDLE)) begin
                overrun_o <= 1'b1;
            end
        end
    end

    // RAM array and its read register are deliberately not reset.
    always_ff @(posedge clock_i) begin
        if (accept_write && mapped) begin
            ram[ram_address] <= data_i;
        end
        if (accept_read) begin
            ram_q <= ram[ram_address];
        end
    end

endmodule

// File: tb/tb_cpu_work_ram.sv
// Bench for cpu_work_ram: vector table plus scoreboarded read
// responses with latency checks, and hand-written corner sequences.
module tb_cpu_work_ram;

    localparam int LAT = 2;

    logic        clock;
    logic        reset;
    logic [15:0] address;
    logic        address_valid;
    logic [7:0]  wdata;
    logic        wdata_valid;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } resp_t;

    resp_t exp_q[$];

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[10];

    cpu_work_ram #(
        .RAM_ADDRESS_WIDTH(11),
        .MAP_LIMIT(16'h2000),
        .READ_LATENCY(LAT)
    ) dut (
        .clock_i(clock),
        .reset_i(reset),
        .address_i(address),
        .address_valid_i(address_valid),
        .data_i(wdata),
        .data_valid_i(wdata_valid),
        .data_o(rdata),
        .data_valid_o(rdata_valid),
        .overrun_o(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every strobe must match the queue head, on time.
    always @(negedge clock) begin
        if (!reset) begin
            if (rdata_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    check("read_data", {24'd0, rdata}, {24'd0, exp_q[0].data});
                    check("read_latency", cyc, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                check("missing_valid", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // One request per call, presented for one cycle after the next edge.
    task automatic drive(input logic v, input logic wr,
                         input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] e, input logic push);
        resp_t r;
        @(posedge clock);
        #1;
        address_valid = v;
        wdata_valid   = v & wr;
        address       = a;
        wdata         = d;
        if (push) begin
            r.data = e;
            r.due  = cyc + LAT;
            exp_q.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0123, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 16'h0123, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 16'h0042, 8'h3C, 8'h00};
        vecs[3] = '{1'b0, 16'h0842, 8'h00, 8'h3C};
        vecs[4] = '{1'b0, 16'h1042, 8'h00, 8'h3C};
        vecs[5] = '{1'b0, 16'h1842, 8'h00, 8'h3C};
        vecs[6] = '{1'b1, 16'h4000, 8'h77, 8'h00};
        vecs[7] = '{1'b0, 16'h4000, 8'h00, 8'h77};
        vecs[8] = '{1'b0, 16'h0123, 8'h00, 8'hA5};
        vecs[9] = '{1'b0, 16'h6000, 8'h00, 8'hA5};

        reset         = 1'b1;
        address       = 16'h0;
        address_valid = 1'b0;
        wdata         = 8'h0;
        wdata_valid   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_data", {24'd0, rdata}, 32'h00);
        check("reset_valid", {31'd0, rdata_valid}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        idle(2);
        check("idle_data", {24'd0, rdata}, 32'h00);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].data,
                  vecs[i].exp, !vecs[i].wr);
            idle(4);
        end
        check("data_hold", {24'd0, rdata}, 32'hA5);
        check("no_overrun_table", {31'd0, overrun}, 32'd0);

        // Back-to-back writes, then a read right behind the last write.
        drive(1'b1, 1'b1, 16'h0000, 8'h11, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 16'h0001, 8'h22, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 16'h0002, 8'h33, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 16'h0002, 8'h00, 8'h33, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 16'h0000, 8'h00, 8'h11, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 16'h0001, 8'h00, 8'h22, 1'b1);
        idle(4);
        check("no_overrun_b2b", {31'd0, overrun}, 32'd0);

        // Earliest legal follow-up request is accepted.
        drive(1'b1, 1'b0, 16'h0123, 8'h00, 8'hA5, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 16'h0042, 8'h00, 8'h3C, 1'b1);
        idle(4);
        check("no_overrun_earliest", {31'd0, overrun}, 32'd0);

        // Write during WAIT is dropped and flags overrun.
        drive(1'b1, 1'b0, 16'h0123, 8'h00, 8'hA5, 1'b1);
        drive(1'b1, 1'b1, 16'h0123, 8'hFF, 8'h00, 1'b0);
        idle(4);
        check("overrun_wait", {31'd0, overrun}, 32'd1);
        drive(1'b1, 1'b0, 16'h0123, 8'h00, 8'hA5, 1'b1);
        idle(4);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a pending read.
        drive(1'b1, 1'b0, 16'h0042, 8'h00, 8'h3C, 1'b0);
        @(posedge clock);
        #1;
        address_valid = 1'b0;
        reset         = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, rdata_valid}, 32'd0);
        check("rst_mid_data", {24'd0, rdata}, 32'h00);
        check("rst_mid_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(4);
        check("post_rst_data", {24'd0, rdata}, 32'h00);
        drive(1'b1, 1'b0, 16'h0123, 8'h00, 8'hA5, 1'b1);
        idle(4);
        check("post_rst_overrun", {31'd0, overrun}, 32'd0);

        // Request during RESPOND is dropped; the response still arrives.
        drive(1'b1, 1'b0, 16'h0842, 8'h00, 8'h3C, 1'b1);
        idle(1);
        drive(1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0);
        idle(5);
        check("overrun_respond", {31'd0, overrun}, 32'd1);
        check("respond_hold", {24'd0, rdata}, 32'h3C);

        idle(3);
        check("pending_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
